hazard_arbiter: RTL
===================

# hazard_arbiter

Parametrised hazard and interrupt controller for the pipelined CPU, sitting beside the stage registers. It detects load-use and branch data hazards and arbitrates between them, a configurable number of interrupt sources, and UART reprogramming. It drives one 2-bit control code per stage register, plus pc_reset, uart_disable and status outputs for vga_unit. Compared with the previous single-source controller, it adds:
- parametrised stage and interrupt count;
- pending-interrupt latching;
- register-0 conflict masking;
- a stall counter and a watchdog.

## Interface
Parameters:
- STAGE_CNT, 5: number of stage registers controlled; minimum 3. Stage index 0 = IF, 1 = ID, 2 = EX.
- REG_IDX_W, 5: register-file index width.
- PC_W, 32: PC width.
- PC_MAX, 32'h0000_3FFC: highest valid instruction address.
- IRQ_CNT, 4: number of interrupt sources (1..8). Index 0 has the highest priority.
- WDOG_W, 16: watchdog counter width.

Ports:
- clk  in  1  system clock; state updates on the falling edge.
- rst_n  in  1  synchronous, active-low reset.
- reg_1_valid, reg_2_valid  in  1 each  the ID-stage source registers are read.
- branch_instruction  in  1  the ID-stage instruction is a branch.
- ex_mem_read_enable, ex_reg_write_enable, ex_no_op  in  1 each  EX-stage flags.
- mem_reg_write_enable, mem_no_op  in  1 each  MEM-stage flags.
- id_reg_1_idx, id_reg_2_idx, ex_reg_dest_idx, mem_reg_dest_idx  in  REG_IDX_W each  register indices.
- pc_next  in  PC_W  next fetch address.
- uart_start  in  1  user request to reprogram.
- uart_complete  in  1  UART download finished.
- irq_req  in  IRQ_CNT  one-cycle request pulses.
- irq_done  in  IRQ_CNT  per-source service-complete pulses.
- hazard_control  out  2*STAGE_CNT  per-stage control; bits [2i+1:2i] drive stage i. Encoding: 00 NORMAL, 01 HOLD, 10 NO_OP.
- pc_reset  out  1  one-cycle pulse that restarts fetch at 0.
- uart_disable  out  1  holds the UART unit in reset while 1.
- cpu_state  out  2  00 IDLE, 01 EXECUTE, 10 HAZARD, 11 INTERRUPT.
- issue_type  out  2  00 NONE, 01 DATA, 10 UART, 11 IRQ.
- irq_id  out  3  index of the source being serviced.
- stall_cycles  out  16  saturating count of DATA-stall cycles.
- wdog_err  out  1  sticky watchdog flag.

## Operation
Conflict detection (combinational):
- conflict_X = X_reg_write_enable & ~X_no_op & ((reg_1_valid & id_reg_1_idx == X_dest & id_reg_1_idx != 0) | (reg_2_valid & id_reg_2_idx == X_dest & id_reg_2_idx != 0)), for X = ex, mem.
- data_hazard = (branch_instruction & (conflict_ex | conflict_mem)) | (ex_mem_read_enable & conflict_ex).
- uart_hazard = (pc_next > PC_MAX) | uart_start.

Pending interrupts:
- pend[k] is set by irq_req[k] and cleared when source k's service finishes.
- A request and a clear on the same edge leave pend[k] set.

Reset values: cpu_state IDLE, issue_type NONE, irq_id 0, all controls NORMAL, pc_reset 0, uart_disable 1, pend 0, stall_cycles 0, wdog_err 0, watchdog counter 0.

State machine:
- IDLE -> EXECUTE unconditionally on the next edge.
- EXECUTE, priority data > pend (lowest index first) > uart:
  - DATA: go to HAZARD. IF and ID = HOLD, EX = NO_OP, all others NORMAL.
  - IRQ: go to INTERRUPT, irq_id = lowest set pend bit, all stages NO_OP.
  - UART: go to HAZARD, IF = NO_OP, uart_disable = 0.
- HAZARD/DATA: when data_hazard = 0, go to EXECUTE with all controls NORMAL. stall_cycles increments on every edge spent in HAZARD/DATA and saturates at 16'hFFFF.
- HAZARD/UART: when uart_complete = 1, go to EXECUTE with uart_disable = 1, all controls NORMAL, and pc_reset = 1 for exactly one cycle.
- INTERRUPT: when irq_done[irq_id] = 1, clear pend[irq_id] and go to EXECUTE with all controls NORMAL. irq_done bits for any other index are ignored.
- Leaving HAZARD or INTERRUPT sets issue_type back to NONE.

Watchdog:
- Counts edges spent outside IDLE and EXECUTE; clears to 0 on entering EXECUTE.
- On reaching all-ones, sets wdog_err. The flag stays set until reset and does not change the state machine.

## Timing
- All registers update on the falling clk edge, so the rising-edge stage registers see stable controls.
- Detect-to-control latency: hazard present before edge n gives controls valid after edge n.
- A single-cycle data hazard produces exactly one cycle of HOLD/NO_OP. Controls return to NORMAL after the first edge at which data_hazard = 0.
- Reset sampled low at any edge returns every output to its reset value, even mid-hazard or mid-interrupt. Pending interrupts are lost.
- A new hazard is evaluated only in EXECUTE. The cycle in which a resolution occurs issues no new hazard.

## Test plan
- Load into x5 in EX (ex_mem_read_enable = 1), ID reads x5: one cycle with IF/ID HOLD and EX NO_OP, then NORMAL; stall_cycles = 1. Repeating the same sequence with x0 as the register produces no stall.
- Branch depends on the MEM-stage destination while irq_req[2] pulses in the same cycle: DATA is serviced first. Next, INTERRUPT with irq_id = 2 and all stages NO_OP until irq_done[2], then EXECUTE.
- irq_req[3] and irq_req[1] pulse during INTERRUPT for source 0: after irq_done[0], source 1 is serviced, then source 3.
- pc_next = PC_MAX + 4: uart_disable goes 0 and IF = NO_OP. After uart_complete, one pc_reset pulse, uart_disable returns to 1, and cpu_state = EXECUTE.
- WDOG_W = 4, no irq_done for 15 edges: wdog_err = 1 and stays 1 after the interrupt resolves.
- rst_n low for one edge during HAZARD/UART: all outputs at reset values, IDLE, then EXECUTE on the following edge.

Source files
------------

// File: rtl/hazard_arbiter.sv
// Hazard/interrupt arbiter for the pipelined CPU: detects data and UART hazards,
// latches interrupt requests and drives per-stage control codes on the falling clk edge.
module hazard_arbiter #(
    parameter int              STAGE_CNT = 5,
    parameter int              REG_IDX_W = 5,
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] PC_MAX    = PC_W'(32'h0000_3FFC),
    parameter int              IRQ_CNT   = 4,
    parameter int              WDOG_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   reg_1_valid,
    input  logic                   reg_2_valid,
    input  logic                   branch_instruction,
    input  logic                   ex_mem_read_enable,
    input  logic                   ex_reg_write_enable,
    input  logic                   ex_no_op,
    input  logic                   mem_reg_write_enable,
    input  logic                   mem_no_op,
    input  logic [REG_IDX_W-1:0]   id_reg_1_idx,
    input  logic [REG_IDX_W-1:0]   id_reg_2_idx,
    input  logic [REG_IDX_W-1:0]   ex_reg_dest_idx,
    input  logic [REG_IDX_W-1:0]   mem_reg_dest_idx,
    input  logic [PC_W-1:0]        pc_next,
    input  logic                   uart_start,
    input  logic                   uart_complete,
    input  logic [IRQ_CNT-1:0]     irq_req,
    input  logic [IRQ_CNT-1:0]     irq_done,
    output logic [2*STAGE_CNT-1:0] hazard_control,
    output logic                   pc_reset,
    output logic                   uart_disable,
    output logic [1:0]             cpu_state,
    output logic [1:0]             issue_type,
    output logic [2:0]             irq_id,
    output logic [15:0]            stall_cycles,
    output logic                   wdog_err
);

    // state     | meaning
    // S_IDLE    | just out of reset, moves to EXECUTE on the next edge
    // S_EXEC    | normal flow, new hazards/interrupts arbitrated here only
    // S_HAZARD  | DATA stall or UART reprogramming in progress (see issue_q)
    // S_IRQ     | servicing pending interrupt irq_id_q, pipeline flushed
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_EXEC   = 2'b01,
        S_HAZARD = 2'b10,
        S_IRQ    = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        I_NONE = 2'b00,
        I_DATA = 2'b01,
        I_UART = 2'b10,
        I_IRQ  = 2'b11
    } issue_t;

    localparam logic [1:0] C_HOLD  = 2'b01;
    localparam logic [1:0] C_NO_OP = 2'b10;
    localparam int         CTRL_W  = 2 * STAGE_CNT;

    state_t              state_q, state_d;
    issue_t              issue_q, issue_d;
    logic [2:0]          irq_id_q, irq_id_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                pc_reset_q, pc_reset_d;
    logic                uart_dis_q, uart_dis_d;
    logic [IRQ_CNT-1:0]  pend_q, pend_d;
    logic [15:0]         stall_q, stall_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                wdog_err_q, wdog_err_d;

    logic                conflict_ex, conflict_mem, data_hazard, uart_hazard;
    logic [CTRL_W-1:0]   ctrl_data, ctrl_irq, ctrl_uart;
    logic [2:0]          irq_sel;
    logic                done_hit;
    logic [IRQ_CNT-1:0]  id_onehot, irq_clr;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    always_comb begin
        conflict_ex  = ex_reg_write_enable & ~ex_no_op &
                       ((reg_1_valid & (id_reg_1_idx == ex_reg_dest_idx) & (id_reg_1_idx != '0)) |
                        (reg_2_valid & (id_reg_2_idx == ex_reg_dest_idx) & (id_reg_2_idx != '0)));
        conflict_mem = mem_reg_write_enable & ~mem_no_op &
                       ((reg_1_valid & (id_reg_1_idx == mem_reg_dest_idx) & (id_reg_1_idx != '0)) |
                        (reg_2_valid & (id_reg_2_idx == mem_reg_dest_idx) & (id_reg_2_idx != '0)));
        data_hazard  = (branch_instruction & (conflict_ex | conflict_mem)) |
                       (ex_mem_read_enable & conflict_ex);
        uart_hazard  = (pc_next > PC_MAX) | uart_start;
    end

    always_comb begin
        ctrl_data = '0;
        ctrl_uart = '0;
        ctrl_irq  = '0;
        for (int s = 0; s < STAGE_CNT; s++) begin
            ctrl_irq[2*s +: 2] = C_NO_OP;
        end
        ctrl_data[1:0] = C_HOLD;
        ctrl_data[3:2] = C_HOLD;
        ctrl_data[5:4] = C_NO_OP;
        ctrl_uart[1:0] = C_NO_OP;
    end

    // Lowest set pending bit wins; also decode the source currently in service.
    always_comb begin
        irq_sel   = '0;
        done_hit  = 1'b0;
        id_onehot = '0;
        for (int k = IRQ_CNT - 1; k >= 0; k--) begin
            if (pend_q[k]) irq_sel = 3'(k);
        end
        for (int k = 0; k < IRQ_CNT; k++) begin
            if (irq_id_q == 3'(k)) begin
                done_hit     = irq_done[k];
                id_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        issue_d    = issue_q;
        irq_id_d   = irq_id_q;
        ctrl_d     = ctrl_q;
        pc_reset_d = 1'b0;
        uart_dis_d = uart_dis_q;
        irq_clr    = '0;
        case (state_q)
            S_IDLE: state_d = S_EXEC;
            S_EXEC: begin
                if (data_hazard) begin
                    state_d = S_HAZARD;
                    issue_d = I_DATA;
                    ctrl_d  = ctrl_data;
                end else if (|pend_q) begin
                    state_d  = S_IRQ;
                    issue_d  = I_IRQ;
                    irq_id_d = irq_sel;
                    ctrl_d   = ctrl_irq;
                end else if (uart_hazard) begin
                    state_d    = S_HAZARD;
                    issue_d    = I_UART;
                    ctrl_d     = ctrl_uart;
                    uart_dis_d = 1'b0;
                end
            end
            S_HAZARD: begin
                if (issue_q == I_DATA) begin
                    if (!data_hazard) begin
                        state_d = S_EXEC;
                        issue_d = I_NONE;
                        ctrl_d  = '0;
                    end
                end else if (uart_complete) begin
                    state_d    = S_EXEC;
                    issue_d    = I_NONE;
                    ctrl_d     = '0;
                    uart_dis_d = 1'b1;
                    pc_reset_d = 1'b1;
                end
            end
            S_IRQ: begin
                if (done_hit) begin
                    state_d = S_EXEC;
                    issue_d = I_NONE;
                    ctrl_d  = '0;
                    irq_clr = id_onehot;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A request on the same edge as its clear keeps the bit set.
    always_comb begin
        pend_d  = (pend_q & ~irq_clr) | irq_req;
        stall_d = stall_q;
        if (state_q == S_HAZARD && issue_q == I_DATA && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
        wdog_d = wdog_q;
        if (state_d == S_EXEC) begin
            wdog_d = '0;
        end else if ((state_q == S_HAZARD || state_q == S_IRQ) && wdog_q != '1) begin
            wdog_d = wdog_q + 1'b1;
        end
        wdog_err_d = wdog_err_q | (wdog_d == '1);
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            issue_q    <= I_NONE;
            irq_id_q   <= '0;
            ctrl_q     <= '0;
            pc_reset_q <= 1'b0;
            uart_dis_q <= 1'b1;
            pend_q     <= '0;
            stall_q    <= '0;
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            irq_id_q   <= irq_id_d;
            ctrl_q     <= ctrl_d;
            pc_reset_q <= pc_reset_d;
            uart_dis_q <= uart_dis_d;
            pend_q     <= pend_d;
            stall_q    <= stall_d;
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign hazard_control = ctrl_q;
    assign pc_reset       = pc_reset_q;
    assign uart_disable   = uart_dis_q;
    assign cpu_state      = state_q;
    assign issue_type     = issue_q;
    assign irq_id         = irq_id_q;
    assign stall_cycles   = stall_q;
    assign wdog_err       = wdog_err_q;

endmodule
